// File: rtl/result_unloader.sv
// Result-memory reader: walks addresses 0..N*N-1, reads each RES_W-bit result and
// streams it out LSB-chunk first over a valid/ready interface, flagging the final chunk.
module result_unloader #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8,
  parameter int ADDR_W     = 16,
  localparam int RES_W     = 2*DATA_WIDTH+2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [RES_W-1:0]      mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int CHUNKS = (RES_W + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N*N-1);
  localparam logic [CW-1:0]     LAST_CHUNK = CW'(CHUNKS-1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       chunk_q, chunk_d;
  logic [RES_W-1:0]    sreg_q, sreg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    chunk_d     = chunk_q;
    sreg_d      = sreg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_en_d    = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = READ;
          addr_d      = '0;
          busy_d      = 1'b1;
          mem_en_d    = 1'b1;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = '0;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        // Memory data is valid now, one cycle after the registered read strobe.
        sreg_d      = mem_data;
        chunk_d     = '0;
        state_d     = SEND;
        out_valid_d = 1'b1;
        out_last_d  = (addr_q == LAST_ADDR) && (LAST_CHUNK == '0);
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          if (chunk_q < LAST_CHUNK) begin
            sreg_d     = sreg_q >> DATA_WIDTH;
            chunk_d    = chunk_q + CW'(1);
            out_last_d = (addr_q == LAST_ADDR) && ((chunk_q + CW'(1)) == LAST_CHUNK);
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (addr_q == LAST_ADDR) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              addr_d      = addr_q + ADDR_W'(1);
              state_d     = READ;
              mem_en_d    = 1'b1;
              mem_rd_en_d = 1'b1;
              mem_addr_d  = addr_q + ADDR_W'(1);
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      chunk_q     <= '0;
      sreg_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      chunk_q     <= chunk_d;
      sreg_q      <= sreg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_en    = mem_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_data  = sreg_q[DATA_WIDTH-1:0];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: three instances (N=2, N=8, N=1) each backed
// by a small synchronous result-memory model; negedge monitors record the streams.
module tb_result_unloader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- N=2 instance ----------------
  logic        start2 = 1'b0, ready2 = 1'b1;
  logic        busy2, done2, en2, rd2, valid2, last2;
  logic [15:0] addr2;
  logic [17:0] mdata2 = '0;
  logic [7:0]  data2;
  logic [17:0] mem2 [4];
  bit   [7:0]  exp2 [12];

  result_unloader #(.DATA_WIDTH(8), .N(2), .ADDR_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .mem_en(en2), .mem_rd_en(rd2), .mem_addr(addr2), .mem_data(mdata2),
    .out_data(data2), .out_valid(valid2), .out_ready(ready2), .out_last(last2));

  always @(posedge clk) if (en2 && rd2) mdata2 <= mem2[addr2[1:0]];

  bit [7:0] got2[$];
  bit       lastq2[$];
  int done_cnt2 = 0, rd_cnt2 = 0, last_cyc2 = 0, done_cyc2 = 0;
  always @(negedge clk) begin
    if (valid2 && ready2) begin
      got2.push_back(data2);
      lastq2.push_back(last2);
      if (last2) last_cyc2 = cyc;
    end
    if (done2) begin done_cnt2++; done_cyc2 = cyc; end
    if (rd2) rd_cnt2++;
  end

  // ---------------- N=8 instance ----------------
  logic        start8 = 1'b0, ready8 = 1'b1;
  logic        busy8, done8, en8, rd8, valid8, last8;
  logic [15:0] addr8;
  logic [17:0] mdata8 = '0;
  logic [7:0]  data8;
  logic [17:0] mem8 [64];

  result_unloader #(.DATA_WIDTH(8), .N(8), .ADDR_W(16)) u8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .mem_en(en8), .mem_rd_en(rd8), .mem_addr(addr8), .mem_data(mdata8),
    .out_data(data8), .out_valid(valid8), .out_ready(ready8), .out_last(last8));

  always @(posedge clk) if (en8 && rd8) mdata8 <= mem8[addr8[5:0]];

  bit [7:0] got8[$];
  int done_cnt8 = 0, rd_cnt8 = 0, last_cnt8 = 0;
  always @(negedge clk) begin
    if (valid8 && ready8) begin
      got8.push_back(data8);
      if (last8) last_cnt8++;
    end
    if (done8) done_cnt8++;
    if (rd8) rd_cnt8++;
  end

  // ---------------- N=1 instance ----------------
  logic        start1 = 1'b0, ready1 = 1'b1;
  logic        busy1, done1, en1, rd1, valid1, last1;
  logic [15:0] addr1;
  logic [17:0] mdata1 = '0;
  logic [7:0]  data1;
  logic [17:0] mem1;

  result_unloader #(.DATA_WIDTH(8), .N(1), .ADDR_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_en(en1), .mem_rd_en(rd1), .mem_addr(addr1), .mem_data(mdata1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready1), .out_last(last1));

  always @(posedge clk) if (en1 && rd1) mdata1 <= mem1;

  bit [7:0] got1[$];
  bit       lastq1[$];
  int done_cnt1 = 0;
  always @(negedge clk) begin
    if (valid1 && ready1) begin
      got1.push_back(data1);
      lastq1.push_back(last1);
    end
    if (done1) done_cnt1++;
  end

  task automatic clear2();
    got2.delete(); lastq2.delete();
    done_cnt2 = 0; rd_cnt2 = 0; last_cyc2 = -1; done_cyc2 = -2;
  endtask

  task automatic pulse_start2();
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy2, done2, en2, rd2, addr2, data2, valid2, last2} !== 30'd0) begin
      failures++;
      $display("FAIL reset_n2 outputs got=%h want=0", {busy2, done2, en2, rd2, addr2, data2, valid2, last2});
    end
    checks++;
    if ({busy8, done8, en8, rd8, addr8, data8, valid8, last8, busy1, valid1, last1, done1} !== 34'd0) begin
      failures++;
      $display("FAIL reset_n8_n1 outputs got=%h want=0", {busy8, done8, en8, rd8, addr8, data8, valid8, last8, busy1, valid1, last1, done1});
    end
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy2, valid2, en2, done2} !== 4'd0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=0000", {busy2, valid2, en2, done2});
    end
  endtask

  task automatic test_stream_n2();
    clear2();
    ready2 = 1'b1;
    pulse_start2();
    checks++;
    if (busy2 !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b want=1", busy2); end
    for (int i = 0; i < 200 && done_cnt2 == 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (got2.size() !== 12) begin failures++; $display("FAIL stream_len got=%0d want=12", got2.size()); end
    for (int i = 0; i < 12 && i < got2.size(); i++) begin
      checks++;
      if (got2[i] !== exp2[i] || lastq2[i] !== (i == 11)) begin
        failures++;
        $display("FAIL stream_byte[%0d] got=%h last=%b want=%h last=%b", i, got2[i], lastq2[i], exp2[i], i == 11);
      end
    end
    checks++;
    if (done_cnt2 !== 1 || done_cyc2 !== last_cyc2 + 1) begin
      failures++;
      $display("FAIL done_pulse got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt2, done_cyc2, last_cyc2 + 1);
    end
    checks++;
    if (rd_cnt2 !== 4 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL reads_busy got rd=%0d busy=%b want rd=4 busy=0", rd_cnt2, busy2);
    end
  endtask

  task automatic test_backpressure();
    int seen;
    clear2();
    ready2 = 1'b1;
    pulse_start2();
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (valid2 && data2 == 8'hCD) seen = 1;
    end
    checks++;
    if (seen !== 1) begin failures++; $display("FAIL bp_first_byte got=none want=cd"); end
    @(posedge clk); #1 ready2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (data2 !== 8'hAB || valid2 !== 1'b1 || rd2 !== 1'b0 || addr2 !== 16'd0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got data=%h valid=%b rd=%b addr=%0d want ab 1 0 0", i, data2, valid2, rd2, addr2);
      end
    end
    @(posedge clk); #1 ready2 = 1'b1;
    for (int i = 0; i < 200 && done_cnt2 == 0; i++) @(negedge clk);
    checks++;
    if (got2.size() !== 12) begin failures++; $display("FAIL bp_len got=%0d want=12", got2.size()); end
    for (int i = 0; i < 12 && i < got2.size(); i++) begin
      checks++;
      if (got2[i] !== exp2[i]) begin
        failures++;
        $display("FAIL bp_byte[%0d] got=%h want=%h", i, got2[i], exp2[i]);
      end
    end
  endtask

  task automatic test_random_n8();
    got8.delete(); done_cnt8 = 0; rd_cnt8 = 0; last_cnt8 = 0;
    ready8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    for (int i = 0; i < 3000 && done_cnt8 == 0; i++) begin
      @(posedge clk); #1 ready8 = 1'($urandom_range(0, 1));
    end
    ready8 = 1'b1;
    @(negedge clk);
    checks++;
    if (got8.size() !== 192 || rd_cnt8 !== 64 || done_cnt8 !== 1 || last_cnt8 !== 1) begin
      failures++;
      $display("FAIL n8_counts got bytes=%0d rd=%0d done=%0d last=%0d want 192 64 1 1", got8.size(), rd_cnt8, done_cnt8, last_cnt8);
    end
    for (int e = 0; e < 64 && 3*e+2 < got8.size(); e++) begin
      checks++;
      if ({got8[3*e+2], got8[3*e+1], got8[3*e]} !== {6'd0, mem8[e]}) begin
        failures++;
        $display("FAIL n8_elem[%0d] got=%h want=%h", e, {got8[3*e+2], got8[3*e+1], got8[3*e]}, {6'd0, mem8[e]});
      end
    end
  endtask

  task automatic test_restart_ignored();
    int seen;
    clear2();
    ready2 = 1'b1;
    pulse_start2();
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (rd2 && addr2 == 16'd1) seen = 1;
    end
    checks++;
    if (seen !== 1) begin failures++; $display("FAIL restart_reach_addr1 got=none want=addr1"); end
    pulse_start2();
    for (int i = 0; i < 200 && done_cnt2 == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (got2.size() !== 12 || done_cnt2 !== 1 || rd_cnt2 !== 4 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL restart_counts got bytes=%0d done=%0d rd=%0d busy=%b want 12 1 4 0", got2.size(), done_cnt2, rd_cnt2, busy2);
    end
    for (int i = 0; i < 12 && i < got2.size(); i++) begin
      checks++;
      if (got2[i] !== exp2[i]) begin
        failures++;
        $display("FAIL restart_byte[%0d] got=%h want=%h", i, got2[i], exp2[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int seen;
    clear2();
    ready2 = 1'b1;
    pulse_start2();
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (valid2 && addr2 == 16'd2) seen = 1;
    end
    checks++;
    if (seen !== 1) begin failures++; $display("FAIL arst_reach_addr2 got=none want=addr2"); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy2, done2, en2, rd2, addr2, data2, valid2, last2} !== 30'd0) begin
      failures++;
      $display("FAIL arst_outputs got=%h want=0", {busy2, done2, en2, rd2, addr2, data2, valid2, last2});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt2 !== 0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL arst_no_done got done=%0d busy=%b want 0 0", done_cnt2, busy2);
    end
    clear2();
    pulse_start2();
    for (int i = 0; i < 200 && done_cnt2 == 0; i++) @(negedge clk);
    checks++;
    if (got2.size() !== 12 || done_cnt2 !== 1) begin
      failures++;
      $display("FAIL arst_rerun got bytes=%0d done=%0d want 12 1", got2.size(), done_cnt2);
    end
    for (int i = 0; i < 12 && i < got2.size(); i++) begin
      checks++;
      if (got2[i] !== exp2[i]) begin
        failures++;
        $display("FAIL arst_rerun_byte[%0d] got=%h want=%h", i, got2[i], exp2[i]);
      end
    end
  endtask

  task automatic test_n1();
    int lat;
    got1.delete(); lastq1.delete(); done_cnt1 = 0;
    ready1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) start1 = 1'b0;
      if (valid1) lat = k;
    end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL n1_latency got=%0d want=3", lat); end
    for (int i = 0; i < 50 && done_cnt1 == 0; i++) @(negedge clk);
    checks++;
    if (got1.size() !== 3 || done_cnt1 !== 1) begin
      failures++;
      $display("FAIL n1_counts got bytes=%0d done=%0d want 3 1", got1.size(), done_cnt1);
    end
    if (got1.size() == 3) begin
      checks++;
      if ({got1[2], got1[1], got1[0]} !== 24'h03FFFF || {lastq1[2], lastq1[1], lastq1[0]} !== 3'b100) begin
        failures++;
        $display("FAIL n1_bytes got=%h last=%b want=03ffff last=100", {got1[2], got1[1], got1[0]}, {lastq1[2], lastq1[1], lastq1[0]});
      end
    end
  endtask

  initial begin
    mem2[0] = 18'h2ABCD; mem2[1] = 18'h00001; mem2[2] = 18'h3FFFF; mem2[3] = 18'h10080;
    exp2[0] = 8'hCD; exp2[1]  = 8'hAB; exp2[2]  = 8'h02; exp2[3]  = 8'h01;
    exp2[4] = 8'h00; exp2[5]  = 8'h00; exp2[6]  = 8'hFF; exp2[7]  = 8'hFF;
    exp2[8] = 8'h03; exp2[9]  = 8'h80; exp2[10] = 8'h00; exp2[11] = 8'h01;
    for (int i = 0; i < 64; i++) mem8[i] = 18'(i * 70001 + 12345);
    mem1 = 18'h3FFFF;

    test_reset();
    test_stream_n2();
    test_backpressure();
    test_random_n8();
    test_restart_ignored();
    test_async_reset();
    test_n1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
